// File: rtl/data_mem_responder.sv
// data_mem_responder: RV32I data-memory target, byte/half/word access with WAIT_CYCLES wait states; MISALIGN_TRAP_EN enables the misalign/illegal-f3 trap.
// Latency WAIT_CYCLES+1 cycles from req to the one-cycle ack; no backpressure: busy is high outside IDLE and req is ignored then.
module data_mem_responder #(
   parameter int    DEPTH_WORDS = 256,
   parameter int    WAIT_CYCLES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  f3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        err
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt;
   logic           we_q;
   logic [2:0]     f3_q;
   logic [AW+1:0]  addr_q;
   logic [31:0]    wdata_q;
   logic [31:0]    mem [DEPTH_WORDS];

   logic           a_we;
   logic [2:0]     a_f3;
   logic [AW+1:0]  a_addr;
   logic [31:0]    a_wdata;
   logic [AW-1:0]  idx;
   logic [1:0]     bsel;
   logic [31:0]    word;
   logic [7:0]     byte_v;
   logic [15:0]    half_v;
   logic [31:0]    ld_val;
   logic [31:0]    st_dat;
   logic [3:0]     be;
   logic           bad;
   logic           enter_resp;
   logic           unused_addr;

   assign unused_addr = ^addr[31:AW+2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ack  = (state == S_RESP);
      busy = (state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
      end else if (state == S_IDLE && req) begin
         cnt     <= WAIT_LOAD;
         we_q    <= we;
         f3_q    <= f3;
         addr_q  <= addr[AW+1:0];
         wdata_q <= wdata;
      end else if (state == S_WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // With no wait states the access edge is also the sampling edge, so the live inputs are used.
   assign a_we    = (WAIT_CYCLES == 0) ? we           : we_q;
   assign a_f3    = (WAIT_CYCLES == 0) ? f3           : f3_q;
   assign a_addr  = (WAIT_CYCLES == 0) ? addr[AW+1:0] : addr_q;
   assign a_wdata = (WAIT_CYCLES == 0) ? wdata        : wdata_q;

   assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);
   assign idx        = a_addr[AW+1:2];
   assign bsel       = a_addr[1:0];
   assign word       = mem[idx];
   assign byte_v     = word[{bsel, 3'b000} +: 8];
   assign half_v     = a_addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      ld_val = 32'd0;
      be     = 4'b0000;
      st_dat = a_wdata;
      case (a_f3)
         3'b000: begin
            ld_val = {{24{byte_v[7]}}, byte_v};
            be     = 4'b0001 << bsel;
            st_dat = {4{a_wdata[7:0]}};
         end
         3'b001: begin
            ld_val = {{16{half_v[15]}}, half_v};
            be     = a_addr[1] ? 4'b1100 : 4'b0011;
            st_dat = {2{a_wdata[15:0]}};
         end
         3'b010: begin
            ld_val = word;
            be     = 4'b1111;
         end
         3'b100:  ld_val = {24'd0, byte_v};
         3'b101:  ld_val = {16'd0, half_v};
         default: ld_val = 32'd0;
      endcase
      if (!a_we) be = 4'b0000;
`ifdef MISALIGN_TRAP_EN
      bad = (a_we ? !(a_f3 inside {3'b000, 3'b001, 3'b010})
                  : !(a_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
         || (a_f3[1:0] == 2'b01 && a_addr[0])
         || (a_f3[1:0] == 2'b10 && bsel != 2'b00);
`else
      bad = 1'b0;
`endif
      if (bad) begin
         ld_val = 32'd0;
         be     = 4'b0000;
      end
   end

   // Reset gates the write so an aborted transaction never touches the RAM.
   always_ff @(posedge clk) begin
      if (enter_resp && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= st_dat[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= 32'd0;
         err   <= 1'b0;
      end else if (enter_resp) begin
         rdata <= ld_val;
         err   <= bad;
      end
   end

endmodule
